// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg7_pkg;

    // Scan FSM state encoding
    localparam logic [0:0] StGap   = 1'b0;
    localparam logic [0:0] StDrive = 1'b1;

    // Active-high hex font, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] FONT [16] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111,  // 9
        7'b1110111,  // A
        7'b1111100,  // b
        7'b0111001,  // C
        7'b1011110,  // d
        7'b1111001,  // E
        7'b1110001   // F
    };

    // Map an active-high segment pattern onto the board polarity
    function automatic logic [6:0] pol_seg(input logic [6:0] s, input logic active_low);
        return active_low ? ~s : s;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Font lookup
    always_comb begin
        seg = FONT[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner: one digit per tick, with an all-dark gap after
// each digit change, frame-coherent shadow registers and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned GAP_CYC    = 1,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [4*DIGITS-1:0]        value,
    input  logic [DIGITS-1:0]          dp_in,
    input  logic [DIGITS-1:0]          blank,
    input  logic                       lz_en,
    output logic [DIGITS-1:0]          an,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic [$clog2(DIGITS)-1:0]  digit_idx
);

    localparam int unsigned IdxW = $clog2(DIGITS);
    localparam int unsigned GapW = 4;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);

    logic [0:0]          state_q, state_d;
    logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                load;

    logic [4*DIGITS-1:0] shadow_value_q;
    logic [DIGITS-1:0]   shadow_dp_q;
    logic [DIGITS-1:0]   shadow_blank_q;
    logic                shadow_lz_q;
    // Set by the first frame load; keeps every anode dark until then.
    logic                valid_q;

    logic [DIGITS-1:0]   suppress;
    logic                lz_run;
    logic [3:0]          cur_nib;
    logic [6:0]          cur_seg;

    logic [DIGITS-1:0]   an_d;
    logic [6:0]          seg_d;
    logic                dp_d;

    // Scan FSM: gap countdown, then drive until the next tick
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        idx_d     = idx_q;
        load      = 1'b0;
        case (state_q)
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d   = StDrive;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            StDrive: begin
                if (tick) begin
                    state_d = StGap;
                    load    = (idx_q == LastIdx);
                    idx_d   = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = StGap;
        endcase
    end

    // FSM, index and shadow state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StGap;
            gap_cnt_q      <= '0;
            idx_q          <= '0;
            shadow_value_q <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '1;
            shadow_lz_q    <= 1'b1;
            valid_q        <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            idx_q     <= idx_d;
            if (load) begin
                shadow_value_q <= value;
                shadow_dp_q    <= dp_in;
                shadow_blank_q <= blank;
                shadow_lz_q    <= lz_en;
                valid_q        <= 1'b1;
            end
        end
    end

    // Per-digit suppression: blanked, or a leading zero above digit 0
    always_comb begin
        lz_run   = 1'b1;
        suppress = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_run      = lz_run & (shadow_value_q[4*i +: 4] == 4'h0);
            suppress[i] = shadow_blank_q[i] | (shadow_lz_q & lz_run & (i != 0));
        end
    end

    assign cur_nib = shadow_value_q[4*idx_d +: 4];

    hex_to_seg7 u_dec (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    // Next output pattern from next-state; shadow cannot change while staying in drive
    always_comb begin
        an_d  = '0;
        seg_d = '0;
        dp_d  = 1'b0;
        if (state_d == StDrive && valid_q) begin
            an_d[idx_d] = 1'b1;
            if (!suppress[idx_d]) begin
                seg_d = cur_seg;
                dp_d  = shadow_dp_q[idx_d];
            end
        end
    end

    // Registered board outputs with polarity applied
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= {DIGITS{ACTIVE_LOW}};
            seg <= {7{ACTIVE_LOW}};
            dp  <= ACTIVE_LOW;
        end else begin
            an  <= an_d ^ {DIGITS{ACTIVE_LOW}};
            seg <= pol_seg(seg_d, ACTIVE_LOW);
            dp  <= dp_d ^ ACTIVE_LOW;
        end
    end

    assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random ticks/inputs, every cycle
// compared against a frame-level model of what the display should show.
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int G  = 2;
    localparam bit AL = 1'b1;

    logic           clk;
    logic           reset;
    logic           tick;
    logic [4*D-1:0] value;
    logic [D-1:0]   dp_in;
    logic [D-1:0]   blank;
    logic           lz_en;
    logic [D-1:0]   an;
    logic [6:0]     seg;
    logic           dp;
    logic [1:0]     digit_idx;

    int checks = 0;
    int errors = 0;

    // Independent font table, active high {g,f,e,d,c,b,a}
    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: current digit, dark cycles remaining, and the frame snapshot
    int             m_idx;
    int             m_gap;
    bit             m_valid;
    logic [4*D-1:0] m_val;
    logic [D-1:0]   m_dp;
    logic [D-1:0]   m_blank;
    bit             m_lz;

    seg7_scan_driver #(
        .DIGITS     (D),
        .GAP_CYC    (G),
        .ACTIVE_LOW (AL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .value     (value),
        .dp_in     (dp_in),
        .blank     (blank),
        .lz_en     (lz_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digit_idx (digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idx   = 0;
        m_gap   = G;
        m_valid = 1'b0;
        m_val   = '0;
        m_dp    = '0;
        m_blank = '1;
        m_lz    = 1'b1;
    endtask

    // One clock edge: a tick is honoured only once the dark gap has elapsed
    task automatic model_step(input bit t);
        if (t && m_gap == 0) begin
            if (m_idx == D - 1) begin
                m_val   = value;
                m_dp    = dp_in;
                m_blank = blank;
                m_lz    = lz_en;
                m_valid = 1'b1;
            end
            m_idx = (m_idx + 1) % D;
            m_gap = G;
        end else if (m_gap > 0) begin
            m_gap--;
        end
    endtask

    task automatic check_all(input string tag);
        logic [D-1:0] e_an;
        logic [6:0]   e_seg;
        logic         e_dp;
        bit           sup;
        int           nib;
        e_an  = '0;
        e_seg = '0;
        e_dp  = 1'b0;
        if (m_gap == 0 && m_valid) begin
            e_an = D'(1) << m_idx;
            sup  = m_blank[m_idx] || (m_lz && m_idx != 0 && (m_val >> (4 * m_idx)) == 0);
            nib  = int'((m_val >> (4 * m_idx)) & 16'hF);
            if (!sup) begin
                e_seg = font[nib];
                e_dp  = m_dp[m_idx];
            end
        end
        if (AL) begin
            e_an  = ~e_an;
            e_seg = ~e_seg;
            e_dp  = ~e_dp;
        end
        chk({tag, ".an"}, 32'(an), 32'(e_an));
        chk({tag, ".seg"}, 32'(seg), 32'(e_seg));
        chk({tag, ".dp"}, 32'(dp), 32'(e_dp));
        chk({tag, ".idx"}, 32'(digit_idx), 32'(m_idx));
    endtask

    task automatic step(input bit t, input string tag);
        tick = t;
        @(posedge clk);
        #1;
        model_step(t);
        tick = 1'b0;
        check_all(tag);
    endtask

    task automatic run_ticks(input int n, input int spacing, input string tag);
        for (int k = 0; k < n; k++) begin
            step(1'b1, tag);
            repeat (spacing - 1) step(1'b0, tag);
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must go dark at once
    task automatic do_reset(input string tag);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        reset = 1'b0;
    endtask

    initial begin
        int gap;
        reset = 1'b0;
        tick  = 1'b0;
        value = '0;
        dp_in = '0;
        blank = '0;
        lz_en = 1'b0;
        model_reset();

        #2 reset = 1'b1;
        #1;
        chk("por.an", 32'(an), 32'h0000000F);
        chk("por.seg", 32'(seg), 32'h0000007F);
        chk("por.dp", 32'(dp), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // No ticks: stays dark on digit 0
        repeat (20) step(1'b0, "idle");

        // Plain hex frame
        value = 16'h1234;
        run_ticks(8, 8, "h1234");

        // Leading-zero suppression
        value = 16'h0050;
        lz_en = 1'b1;
        run_ticks(8, 8, "lz0050");
        value = 16'h0000;
        run_ticks(8, 8, "lz0000");
        lz_en = 1'b0;

        // Mid-frame value change must not tear the frame on screen
        value = 16'hAAAA;
        run_ticks(4, 8, "aaaa");
        run_ticks(1, 8, "aaaa");
        value = 16'h5555;
        step(1'b1, "tear");
        repeat (G) step(1'b0, "tear");
        chk("tear.seg_A", 32'(seg), 32'h08);
        chk("tear.an2", 32'(an), 32'h0B);
        repeat (7 - G) step(1'b0, "tear");
        run_ticks(6, 8, "tear");

        // Blank and decimal points
        blank = 4'b0100;
        dp_in = 4'b0001;
        value = 16'h8888;
        run_ticks(8, 8, "blankdp");

        // Reset while driving digit 2, then a too-close tick pair
        run_ticks(2, 8, "pre_rst");
        step(1'b0, "pre_rst");
        do_reset("rst_mid");
        step(1'b1, "post_rst");
        step(1'b1, "post_rst");
        repeat (6) step(1'b0, "post_rst");
        run_ticks(2, 8, "close");
        step(1'b1, "close");
        step(1'b1, "close");
        repeat (6) step(1'b0, "close");
        run_ticks(6, 8, "post_rst");

        // Random inputs and tick spacing, including spacings too close to be legal
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                value = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
                dp_in = 4'($urandom);
                blank = 4'($urandom & $urandom);
                lz_en = 1'($urandom_range(0, 1));
            end
            gap = $urandom_range(1, 10);
            step(1'b1, "rand");
            repeat (gap - 1) step(1'b0, "rand");
            if (it == 150) do_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
